// File: rtl/pa_prefix_adder_pkg.sv
// Shared constants and helpers for the parallel-prefix adder.
// The default operand width and its matching tree depth live here.
package pa_prefix_adder_pkg;

  localparam int WIDTH  = 32;
  localparam int LEVELS = 5;

  // Depth of a Kogge-Stone tree that spans `width` bit positions.
  function automatic int prefix_levels(input int width);
    for (int n = 0; n < 31; n++) begin
      if ((1 << n) >= width) return n;
    end
    return 31;
  endfunction

endpackage

// File: rtl/pa_pg_cell.sv
// Prefix combine cell: (G,P) = (gh | ph&gl, ph&pl).
// The gray variant only produces G; its P output is tied low.
module pa_pg_cell #(
  parameter bit GRAY = 1'b0
) (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);

  generate
    if (GRAY) begin : g_gray
      // Low group already reaches the carry-in, so its propagate is irrelevant.
      logic unused_pl;
      assign unused_pl = pl;
      assign p         = 1'b0;
    end else begin : g_black
      assign p = ph & pl;
    end
  endgenerate

endmodule

// File: rtl/pa_prefix_adder.sv
// Registered WIDTH-bit adder with carry-in, built on a Kogge-Stone carry tree.
// Carry-in is folded into bit 0's generate so the tree covers bits 0..WIDTH-1.
module pa_prefix_adder #(
  parameter int WIDTH = pa_prefix_adder_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             clock,
  input  logic             reset
);

  import pa_prefix_adder_pkg::*;

  localparam int NLEV = prefix_levels(WIDTH);

  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_init;
  logic [WIDTH-1:0] p_init;
  logic [WIDTH-1:0] g_final;
  logic [WIDTH-1:0] p_final;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             unused_p;

  assign g_bit = a & b;
  assign p_bit = a ^ b;

  // Bit 0 absorbs the carry-in as the bit -1 generate term: G[0:-1].
  pa_pg_cell #(.GRAY(1'b1)) u_cin (
    .gh (g_bit[0]),
    .ph (p_bit[0]),
    .gl (c),
    .pl (1'b0),
    .g  (g_init[0]),
    .p  (p_init[0])
  );

  generate
    if (WIDTH > 1) begin : g_upper
      assign g_init[WIDTH-1:1] = g_bit[WIDTH-1:1];
      assign p_init[WIDTH-1:1] = p_bit[WIDTH-1:1];
    end
  endgenerate

  // Level l combines with span 2^l; columns whose low partner is already
  // complete down to the carry-in use gray cells.
  generate
    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
      localparam int SPAN = 1 << l;
      logic [WIDTH-1:0] gi;
      logic [WIDTH-1:0] pi;
      logic [WIDTH-1:0] go;
      logic [WIDTH-1:0] po;

      if (l == 0) begin : g_src_init
        assign gi = g_init;
        assign pi = p_init;
      end else begin : g_src_prev
        assign gi = g_lvl[l-1].go;
        assign pi = g_lvl[l-1].po;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_col
        if (i < SPAN) begin : g_pass
          assign go[i] = gi[i];
          assign po[i] = pi[i];
        end else if (i < 2 * SPAN) begin : g_gray
          pa_pg_cell #(.GRAY(1'b1)) u_cell (
            .gh (gi[i]),
            .ph (pi[i]),
            .gl (gi[i-SPAN]),
            .pl (pi[i-SPAN]),
            .g  (go[i]),
            .p  (po[i])
          );
        end else begin : g_black
          pa_pg_cell #(.GRAY(1'b0)) u_cell (
            .gh (gi[i]),
            .ph (pi[i]),
            .gl (gi[i-SPAN]),
            .pl (pi[i-SPAN]),
            .g  (go[i]),
            .p  (po[i])
          );
        end
      end
    end

    if (NLEV == 0) begin : g_out_flat
      assign g_final = g_init;
      assign p_final = p_init;
    end else begin : g_out_tree
      assign g_final = g_lvl[NLEV-1].go;
      assign p_final = g_lvl[NLEV-1].po;
    end
  endgenerate

  // carry[i] = G[i-1:-1]; carry[0] is the carry-in itself.
  assign carry[0] = c;
  generate
    for (genvar i = 1; i < WIDTH; i++) begin : g_carry
      assign carry[i] = g_final[i-1];
    end
  endgenerate

  assign sum_c    = p_bit ^ carry;
  assign cout_c   = g_final[WIDTH-1];
  assign unused_p = ^p_final;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_c;
      cout <= cout_c;
    end
  end

endmodule

// File: tb/tb_pa_prefix_adder.sv
// Scoreboard bench for pa_prefix_adder: the driver queues expected results,
// a monitor pops one per clock edge and compares after the edge.
module tb_pa_prefix_adder;

  localparam int W = 32;

  typedef struct {
    logic [W:0] exp;
    string      name;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c;
  logic [W-1:0] sum;
  logic         cout;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  pa_prefix_adder #(.WIDTH(W)) dut (
    .a     (a),
    .b     (b),
    .c     (c),
    .sum   (sum),
    .cout  (cout),
    .clock (clock),
    .reset (reset)
  );

  // Reference: plain (W+1)-bit unsigned addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    return r;
  endfunction

  // Drive one operand set, queue its expected result, then let one edge pass.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic r, input logic [W:0] exp, input string nm);
    exp_t e;
    a     = x;
    b     = y;
    c     = ci;
    reset = r;
    e.exp  = exp;
    e.name = nm;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [W:0] got;
    forever begin
      @(posedge clock);
      #2;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {cout, sum};
        checks++;
        if (got === e.exp) passed++;
        else $display("FAIL %s: got cout=%0b sum=0x%h, expected cout=%0b sum=0x%h",
                      e.name, got[W], got[W-1:0], e.exp[W], e.exp[W-1:0]);
      end
    end
  end

  initial begin : driver
    logic [W-1:0] sa [7];
    logic [W-1:0] sbv[7];
    logic [W-1:0] se [7];
    logic [W-1:0] x, y;
    logic         ci, r;

    sa  = '{111, 222, 333, 444, 666, 323, 112};
    sbv = '{222, 333, 444, 555,  23, 457,  72};
    se  = '{333, 555, 777, 999, 689, 780, 184};

    issue(32'd5, 32'd7, 1'b0, 1'b1, 33'd0, "reset_hold0");
    issue(32'd5, 32'd7, 1'b0, 1'b1, 33'd0, "reset_hold1");
    issue(32'd5, 32'd7, 1'b0, 1'b0, 33'd12, "reset_release");

    for (int i = 0; i < 7; i++) begin
      issue(sa[i], sbv[i], 1'b0, 1'b0, {1'b0, se[i]}, "stream_first");
      issue(sa[i], sbv[i], 1'b0, 1'b0, {1'b0, se[i]}, "stream_hold");
    end

    issue(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b1, 32'h0}, "carry_ones_plus_cin");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, {1'b1, 32'hFFFF_FFFF}, "carry_all_ones");
    issue(32'h0, 32'h0, 1'b1, 1'b0, 33'd1, "cin_only");
    issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 32'h8000_0000}, "msb_carry");

    issue(32'd40, 32'd2, 1'b0, 1'b0, 33'd42, "pre_reset_mid");
    issue(32'd1000, 32'd2000, 1'b0, 1'b1, 33'd0, "reset_mid");
    issue(32'd1000, 32'd2000, 1'b0, 1'b0, 33'd3000, "after_reset_mid");

    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 7))
        0:       x = 32'hFFFF_FFFF;
        1:       x = 32'h0;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       y = 32'hFFFF_FFFF;
        1:       y = 32'h0;
        default: y = $urandom;
      endcase
      ci = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 99) == 0);
      issue(x, y, ci, r, r ? 33'd0 : ref_add(x, y, ci), "random");
    end

    reset = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d results still pending, expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
